rr_arbiter8: RTL and testbench

- Round-robin arbiter that shares one resource between 8 requesters.
- Output is a one-hot 8-bit grant, i.e. a 3-to-8 decode of the registered grant index, plus the encoded index for the downstream select mux.
- Sits between 8 request sources and a single shared datapath.
- A grant is held until its requester releases. An optional timeout can force release.

---
 rtl/rr_arbiter8_if.sv | 27 ++
 rtl/rr_arbiter8.sv | 109 ++++++++++
 tb/tb_rr_arbiter8.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter8_if.sv
// rtl/rr_arbiter8_if.sv - request/grant bundle between the requesters and rr_arbiter8
interface rr_arbiter8_if;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with held grants; RR_TIMEOUT_EN adds forced release
module rr_arbiter8 #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    rr_arbiter8_if.slave bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [7:0] gnt_q;
    logic [2:0] idx_q;
    logic       valid_q;

    logic [2:0] sel;
    logic [2:0] cand;
    logic       found;

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("rr_arbiter8: HOLD_MAX must be within 2..255");
    end
    if ((64'd1 << CNT_W) <= 64'(HOLD_MAX)) begin : g_bad_cnt_w
        $error("rr_arbiter8: CNT_W too narrow for HOLD_MAX");
    end

    // Circular search starting at ptr: the last winner sits at ptr-1, i.e. searched last.
    always_comb begin
        sel   = ptr;
        cand  = 3'd0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr + 3'(i);
            if (!found && bus.req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

`ifdef RR_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
    logic             timeout_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ptr     <= 3'd0;
            gnt_q   <= 8'h00;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
`ifdef RR_TIMEOUT_EN
            cnt       <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef RR_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.en && found) begin
                        gnt_q   <= 8'(1) << sel;
                        idx_q   <= sel;
                        valid_q <= 1'b1;
                        ptr     <= sel + 3'd1;
                        state   <= GRANT;
`ifdef RR_TIMEOUT_EN
                        cnt     <= '0;
`endif
                    end
                end
                GRANT: begin
                    // Release wins over everything; other requests wait for the idle cycle.
                    if (!bus.req[idx_q]) begin
                        gnt_q   <= 8'h00;
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
`ifdef RR_TIMEOUT_EN
                    else if (cnt == CNT_W'(HOLD_MAX - 1)) begin
                        gnt_q     <= 8'h00;
                        valid_q   <= 1'b0;
                        timeout_q <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;
`ifdef RR_TIMEOUT_EN
    assign bus.timeout   = timeout_q;
`else
    assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - directed self-checking bench for rr_arbiter8
module tb_rr_arbiter8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    rr_arbiter8_if bus();

    rr_arbiter8 #(.HOLD_MAX(4), .CNT_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        vectors++;
        if ($countones(bus.gnt) > 1) begin
            miscompares++;
            $display("FAIL onehot: gnt=%b has more than one bit set", bus.gnt);
        end
        vectors++;
        if (bus.gnt_valid !== (|bus.gnt)) begin
            miscompares++;
            $display("FAIL valid_vs_gnt: gnt_valid=%b required %b", bus.gnt_valid, |bus.gnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.en  = 1'b0;
        bus.req = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.en  = 1'b1;
        bus.req = 8'hFF;
        repeat (3) tick();
        vectors++;
        if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_gnt: gnt=%h valid=%b required 00/0", bus.gnt, bus.gnt_valid);
        end
        vectors++;
        if (bus.gnt_idx !== 3'd0 || bus.timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idx: idx=%0d timeout=%b required 0/0", bus.gnt_idx, bus.timeout);
        end
        reset_n = 1'b1;
        tick();
        vectors++;
        if (bus.gnt !== 8'h01 || bus.gnt_idx !== 3'd0) begin
            miscompares++;
            $display("FAIL first_grant: gnt=%h idx=%0d required 01/0", bus.gnt, bus.gnt_idx);
        end
    endtask

    task automatic test_rotation();
        logic [7:0] exp_gnt;
        do_reset();
        bus.en  = 1'b1;
        bus.req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            exp_gnt = 8'h01 << (k % 8);
            tick();
            vectors++;
            if (bus.gnt !== exp_gnt || bus.gnt_idx !== 3'(k % 8)) begin
                miscompares++;
                $display("FAIL rot_grant%0d: gnt=%h idx=%0d required %h/%0d", k, bus.gnt, bus.gnt_idx, exp_gnt, k % 8);
            end
            tick();
            vectors++;
            if (bus.gnt !== exp_gnt) begin
                miscompares++;
                $display("FAIL rot_hold%0d: gnt=%h required %h", k, bus.gnt, exp_gnt);
            end
            bus.req = 8'hFF & ~exp_gnt;
            tick();
            vectors++;
            if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rot_idle%0d: gnt=%h valid=%b required 00/0", k, bus.gnt, bus.gnt_valid);
            end
            bus.req = 8'hFF;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.en  = 1'b1;
        bus.req = 8'h20;
        tick();
        vectors++;
        if (bus.gnt !== 8'h20) begin
            miscompares++;
            $display("FAIL wrap_g5: gnt=%h required 20", bus.gnt);
        end
        bus.req = 8'h00;
        tick();
        bus.req = 8'h21;
        tick();
        vectors++;
        if (bus.gnt !== 8'h01 || bus.gnt_idx !== 3'd0) begin
            miscompares++;
            $display("FAIL wrap_g0: gnt=%h idx=%0d required 01/0", bus.gnt, bus.gnt_idx);
        end
        bus.req = 8'h00;
        tick();
        bus.req = 8'h03;
        tick();
        vectors++;
        if (bus.gnt !== 8'h02 || bus.gnt_idx !== 3'd1) begin
            miscompares++;
            $display("FAIL wrap_ptr1: gnt=%h idx=%0d required 02/1", bus.gnt, bus.gnt_idx);
        end
    endtask

    task automatic test_enable();
        do_reset();
        bus.en  = 1'b0;
        bus.req = 8'h04;
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++;
            if (bus.gnt !== 8'h00) begin
                miscompares++;
                $display("FAIL en_block%0d: gnt=%h required 00", k, bus.gnt);
            end
        end
        bus.en = 1'b1;
        tick();
        vectors++;
        if (bus.gnt !== 8'h04 || bus.gnt_idx !== 3'd2) begin
            miscompares++;
            $display("FAIL en_grant: gnt=%h idx=%0d required 04/2", bus.gnt, bus.gnt_idx);
        end
        bus.en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++;
            if (bus.gnt !== 8'h04) begin
                miscompares++;
                $display("FAIL en_keep%0d: gnt=%h required 04", k, bus.gnt);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.en  = 1'b1;
        bus.req = 8'h10;
        tick();
        vectors++;
        if (bus.gnt !== 8'h10) begin
            miscompares++;
            $display("FAIL ar_pre: gnt=%h required 10", bus.gnt);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL ar_drop: gnt=%h valid=%b required 00/0", bus.gnt, bus.gnt_valid);
        end
        tick();
        reset_n = 1'b1;
        bus.req = 8'h11;
        tick();
        vectors++;
        if (bus.gnt !== 8'h01) begin
            miscompares++;
            $display("FAIL ar_ptr0: gnt=%h required 01", bus.gnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.en  = 1'b1;
        bus.req = 8'h03;
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (bus.gnt !== 8'h01 || bus.timeout !== 1'b0) begin
                miscompares++;
                $display("FAIL to_hold%0d: gnt=%h timeout=%b required 01/0", k, bus.gnt, bus.timeout);
            end
        end
`ifdef RR_TIMEOUT_EN
        tick();
        vectors++;
        if (bus.gnt !== 8'h00 || bus.timeout !== 1'b1) begin
            miscompares++;
            $display("FAIL to_release: gnt=%h timeout=%b required 00/1", bus.gnt, bus.timeout);
        end
        tick();
        vectors++;
        if (bus.gnt !== 8'h02 || bus.timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL to_next: gnt=%h timeout=%b required 02/0", bus.gnt, bus.timeout);
        end
`else
        for (int k = 0; k < 6; k++) begin
            tick();
            vectors++;
            if (bus.gnt !== 8'h01 || bus.timeout !== 1'b0) begin
                miscompares++;
                $display("FAIL to_forever%0d: gnt=%h timeout=%b required 01/0", k, bus.gnt, bus.timeout);
            end
        end
`endif
    endtask

    initial begin
        bus.en  = 1'b0;
        bus.req = 8'h00;
        test_reset();
        test_rotation();
        test_wrap();
        test_enable();
        test_async_reset();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
